// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply or restoring
// divide on a shared 33-bit adder, sign fix-up, one registered result per done pulse.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX, ST_DONE} state_t;
    state_t state, state_next;

    logic [2:0]      op_q;
    logic            sign_a, sign_b;
    logic [XLEN-1:0] hi, lo, divisor;
    logic [4:0]      cnt;

    logic            accept, a_signed, b_signed, in_sign_a, in_sign_b, fast;
    logic [XLEN-1:0] mag_a, mag_b, fast_result;

    // Accept decode: signedness, operand magnitudes and the divide fast paths.
    always_comb begin
        accept    = start && !flush && (state == ST_IDLE || state == ST_DONE);
        a_signed  = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        b_signed  = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        in_sign_a = a_signed && A[XLEN-1];
        in_sign_b = b_signed && B[XLEN-1];
        mag_a     = in_sign_a ? -A : A;
        mag_b     = in_sign_b ? -B : B;
        fast        = 1'b0;
        fast_result = '0;
        if (op[2]) begin
            if (B == '0) begin
                fast        = 1'b1;
                fast_result = op[1] ? A : '1;
            end else if (b_signed && A == {1'b1, {(XLEN-1){1'b0}}} && B == '1) begin
                fast        = 1'b1;
                fast_result = op[1] ? '0 : A;
            end
        end
    end

    logic [XLEN:0]     mul_sum, rem_shift, div_diff;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, fix_result;

    // {hi,lo} is the product for multiply and {remainder,quotient} for divide.
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, divisor} : '0);
        rem_shift = {hi, lo[XLEN-1]};
        div_diff  = rem_shift - {1'b0, divisor};
        prod      = {hi, lo};
        prod_fix  = (sign_a ^ sign_b) ? -prod : prod;
        quot_fix  = (sign_a ^ sign_b) ? -lo : lo;
        rem_fix   = sign_a ? -hi : hi;
        if (!op_q[2])
            fix_result = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        else
            fix_result = op_q[1] ? rem_fix : quot_fix;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (accept) state_next = fast ? ST_DONE : ST_RUN;
                else        state_next = ST_IDLE;
            end
            ST_RUN:  if (cnt == '0) state_next = ST_FIX;
            ST_FIX:  state_next = ST_DONE;
            default: state_next = ST_IDLE;
        endcase
        if (flush) state_next = ST_IDLE;
    end

    assign busy = (state == ST_RUN) || (state == ST_FIX);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= '0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            divisor <= '0;
            cnt     <= '0;
            result  <= '0;
        end else if (!flush) begin
            if (accept) begin
                op_q    <= op;
                sign_a  <= in_sign_a;
                sign_b  <= in_sign_b;
                hi      <= '0;
                lo      <= mag_a;
                divisor <= mag_b;
                cnt     <= 5'd31;
                if (fast) result <= fast_result;
            end else if (state == ST_RUN) begin
                cnt <= cnt - 1'b1;
                if (!op_q[2]) begin
                    hi <= mul_sum[XLEN:1];
                    lo <= {mul_sum[0], lo[XLEN-1:1]};
                end else if (!div_diff[XLEN]) begin
                    hi <= div_diff[XLEN-1:0];
                    lo <= {lo[XLEN-2:0], 1'b1};
                end else begin
                    hi <= rem_shift[XLEN-1:0];
                    lo <= {lo[XLEN-2:0], 1'b0};
                end
            end else if (state == ST_FIX) begin
                result <= fix_result;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: hand-computed results, latency, flush/reset
// abort, ignored start and back-to-back issue.
module tb_muldiv_seq;
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  op;
    logic [31:0] A, B;
    logic        busy, done;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    muldiv_seq #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
        .flush(flush), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_n);
        lat = 0;
        busy_n = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] e;
        e = 32'hDEAD_BEEF;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        check(tag, result, e);
    endtask

    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat, busy_n;
        exp_q.push_back(exp_res);
        launch(o, a, b);
        wait_done(lat, busy_n);
        check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        check({tag, ".busy"}, 32'(busy_n), 32'(exp_lat - 1));
        pop_check({tag, ".res"});
        @(negedge clk);
        check({tag, ".pulse"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        int lat, busy_n, done_n;
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.busy", {31'b0, busy}, 32'd0);
        check("rst.done", {31'b0, done}, 32'd0);
        check("rst.result", result, 32'd0);
        rst = 1'b0;

        do_op("mul",      OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        do_op("mul2",     OP_MUL,    32'h1234_5678,  32'h10,        32'h2345_6780, 34);
        do_op("mulh",     OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34);
        do_op("mulhsu",   OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
        do_op("mulhu",    OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        do_op("div",      OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34);
        do_op("rem",      OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34);
        do_op("div_nb",   OP_DIV,    32'd20,         32'hFFFF_FFFD, 32'hFFFF_FFFA, 34);
        do_op("rem_nb",   OP_REM,    32'd20,         32'hFFFF_FFFD, 32'd2,         34);
        do_op("divu",     OP_DIVU,   32'd100,        32'd7,         32'd14,        34);
        do_op("remu",     OP_REMU,   32'd100,        32'd7,         32'd2,         34);
        do_op("div0",     OP_DIV,    32'h55,         32'd0,         32'hFFFF_FFFF, 1);
        do_op("remu0",    OP_REMU,   32'h1234,       32'd0,         32'h1234,      1);
        do_op("div_ovf",  OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_op("rem_ovf",  OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);

        // start pulsed during RUN must not disturb or queue behind the running op
        exp_q.push_back(32'd14);
        launch(OP_DIVU, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        start = 1'b1; op = OP_MUL; A = 32'd1; B = 32'd1;
        @(negedge clk);
        start = 1'b0;
        check("ign.busy", {31'b0, busy}, 32'd1);
        wait_done(lat, busy_n);
        check("ign.lat", 32'(lat + 5), 32'd34);
        pop_check("ign.res");
        @(negedge clk);
        check("ign.noqueue", {31'b0, busy | done}, 32'd0);

        // flush in RUN cycle 10
        launch(OP_MUL, 32'd3, 32'd5);
        repeat (9) @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        check("flush.run", {31'b0, busy}, 32'd1);
        @(negedge clk);
        flush = 1'b0;
        check("flush.busy", {31'b0, busy}, 32'd0);
        check("flush.done", {31'b0, done}, 32'd0);
        check("flush.result", result, 32'd14);
        done_n = 0;
        repeat (45) begin
            @(negedge clk);
            if (done) done_n++;
        end
        check("flush.nodone", 32'(done_n), 32'd0);
        check("flush.hold", result, 32'd14);

        // synchronous reset mid-RUN
        launch(OP_MULHU, 32'hFFFF_FFFF, 32'd3);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mrst.busy", {31'b0, busy}, 32'd0);
        check("mrst.done", {31'b0, done}, 32'd0);
        check("mrst.result", result, 32'd0);
        rst = 1'b0;
        done_n = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_n++;
        end
        check("mrst.nodone", 32'(done_n), 32'd0);

        // back-to-back: new DIVU accepted straight out of DONE
        exp_q.push_back(32'hFFFF_FFEB);
        launch(OP_MUL, 32'd7, 32'hFFFF_FFFD);
        wait_done(lat, busy_n);
        check("b2b1.lat", 32'(lat), 32'd34);
        pop_check("b2b1.res");
        exp_q.push_back(32'd3);
        start = 1'b1; op = OP_DIVU; A = 32'd9; B = 32'd3;
        @(negedge clk);
        start = 1'b0;
        check("b2b.busy", {31'b0, busy}, 32'd1);
        check("b2b.done", {31'b0, done}, 32'd0);
        wait_done(lat, busy_n);
        check("b2b2.lat", 32'(lat + 1), 32'd34);
        check("b2b2.busy", 32'(busy_n + 1), 32'd33);
        pop_check("b2b2.res");
        @(negedge clk);
        check("b2b2.pulse", {31'b0, done}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative RV32M multiply/divide sequencer in the EX stage, beside the single-cycle ALU. The pipeline controller diverts MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU here and holds IF/ID/EX on `busy`. The block runs a 32-iteration shift-add multiply or restoring divide on an internal 33-bit add/sub, applies sign correction, and returns one registered 32-bit result with a one-cycle `done` pulse.

## Interface
Parameters:
- `XLEN`, 32: operand/result width. Only 32 is supported.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `op`  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `A`  in  32  rs1 operand (forwarded value); captured on accept.
- `B`  in  32  rs2 operand; captured on accept.
- `flush`  in  1  abort the current operation (branch/trap kill of EX).
- `busy`  out  1  operation in flight; pipeline stalls while high.
- `done`  out  1  one-cycle pulse; `result` is valid in this cycle.
- `result`  out  32  final value; holds until the next `done`.

## Operation
- States: IDLE, RUN, FIX, DONE.
- Accept condition: `start=1` while in IDLE or DONE and `flush=0`.
- On accept, the block latches `op`, the operand sign flags, |A| and |B| (magnitudes), and loads the iteration counter with 31.
- Signedness:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU, DIVU, REMU, MUL: unsigned magnitudes. MUL low word is sign-agnostic.
- Multiply, one step per RUN cycle: if the product LSB is 1, add the multiplicand into the upper 33 bits; then shift the 64-bit product right by 1.
  - Result sign = signA XOR signB (MULHSU: signA only). Negative results are two's-complement negated over 64 bits in FIX.
  - MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].
- Divide, one step per RUN cycle: shift {rem, quot} left by 1, then trial-subtract the divisor in 33 bits.
  - If the difference is non-negative, keep it and set quot LSB to 1; otherwise restore.
  - Quotient sign = signA XOR signB; remainder sign = signA. Both are applied in FIX.
- Special cases take a fast path, IDLE/DONE -> DONE directly, with no RUN/FIX:
  - B=0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return A.
  - DIV/REM with A=0x80000000, B=0xFFFFFFFF: DIV returns 0x80000000; REM returns 0.
- Transitions:
  - IDLE -> RUN on accept (normal path); IDLE -> DONE on accept (fast path).
  - RUN -> FIX when the counter reaches 0 after its step; otherwise decrement the counter.
  - FIX -> DONE; `result` is registered on this edge.
  - DONE -> RUN or DONE on an accept (back-to-back); otherwise DONE -> IDLE.
- `flush=1` in any state: next state IDLE, no `done`, `result` unchanged. Flush wins over a simultaneous `start`.
- `start` while in RUN or FIX: ignored. It is not queued.

## Timing
- Reset values: state IDLE, `busy=0`, `done=0`, `result=0`, all internal registers 0. Reset mid-operation aborts with no `done`.
- `busy`=1 exactly in RUN and FIX; it is combinational from the state register.
- `done`=1 exactly in DONE; `busy`=0 during DONE.
- Normal latency: accept on edge k, RUN during edges k+1..k+32, FIX on edge k+33. `done` and a valid `result` appear in the cycle after edge k+33.
- Fast-path latency: `done` is high in the cycle after the accepting edge.
- Back-to-back: an accept in DONE makes `busy` high in the very next cycle, with no idle bubble.
- No combinational path from `A`, `B` or `op` to any output.

## Test plan
- MUL A=7, B=0xFFFFFFFD -> `result`=0xFFFFFFEB; `done` exactly 34 cycles after the `start` cycle; `busy` high for 33 cycles.
- MULH 0x80000000×0x80000000 -> 0x40000000.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Special cases, each with `done` one cycle after accept:
  - DIV x/0 -> 0xFFFFFFFF.
  - REMU 0x1234/0 -> 0x1234.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM 0x80000000/0xFFFFFFFF -> 0.
- Abort and ignore behaviour:
  - `flush` at RUN cycle 10 -> IDLE next cycle, no `done`, `result` keeps its prior value.
  - `start` pulsed during RUN is ignored.
  - `rst` mid-RUN -> all outputs 0 on the next cycle.
- Back-to-back: `start` held high through DONE with a new DIVU 9/3 -> `busy` high in the next cycle; second `done` carries 3.
